// File: rtl/vdp_timing_pkg.sv
// Shared types and default geometry for the VDP dot/line timing blocks.
package vdp_timing_pkg;

  typedef enum logic [1:0] {
    DS_00 = 2'b00,
    DS_01 = 2'b01,
    DS_11 = 2'b11,
    DS_10 = 2'b10
  } dotstate_t;

  localparam logic [8:0] X_FIRST_DEFAULT     = 9'h1F8;
  localparam logic [8:0] X_LAST_DEFAULT      = 9'd341;
  localparam logic [8:0] Y_FIRST_DEFAULT     = 9'h1F8;
  localparam logic [8:0] Y_LAST_NTSC_DEFAULT = 9'd264;
  localparam logic [8:0] Y_LAST_PAL_DEFAULT  = 9'd304;
  localparam logic [8:0] WIN_LAST_192        = 9'd191;
  localparam logic [8:0] WIN_LAST_212        = 9'd211;

  // Lines -8..-1 encode as 0x1F8..0x1FF, so an unsigned compare already
  // places them outside the window.
  function automatic logic in_window(input logic [8:0] y, input logic ln);
    return y <= (ln ? WIN_LAST_212 : WIN_LAST_192);
  endfunction

endpackage

// File: rtl/vdp_dot_phase.sv
// Four-clock dot phase Gray counter plus the 8-dot group index latch.
module vdp_dot_phase
  import vdp_timing_pkg::*;
(
  input  logic       CLK21M,
  input  logic       RESET,
  input  logic [8:0] dot_x,
  output dotstate_t  dotstate,
  output logic [2:0] eightdotstate
);

  dotstate_t  state_reg;
  dotstate_t  state_next;
  logic [2:0] eight_reg;

  always_comb begin
    state_next = DS_00;
    case (state_reg)
      DS_00:   state_next = DS_01;
      DS_01:   state_next = DS_11;
      DS_11:   state_next = DS_10;
      DS_10:   state_next = DS_00;
      default: state_next = DS_00;
    endcase
  end

  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      state_reg <= DS_10;
      eight_reg <= 3'd0;
    end else begin
      state_reg <= state_next;
      // dot_x was advanced on the previous (DS_11) edge
      if (state_reg == DS_10) eight_reg <= dot_x[2:0];
    end
  end

  assign dotstate      = state_reg;
  assign eightdotstate = eight_reg;

endmodule

// File: rtl/vdp_dot_timing.sv
// Master dot/line timing generator: X/Y position, active window and sync strobes.
// Optional interlace line cadence enabled by VDP_DOT_TIMING_INTERLACE_EN.
module vdp_dot_timing
  import vdp_timing_pkg::*;
#(
  parameter logic [8:0] X_FIRST     = X_FIRST_DEFAULT,
  parameter logic [8:0] X_LAST      = X_LAST_DEFAULT,
  parameter logic [8:0] Y_FIRST     = Y_FIRST_DEFAULT,
  parameter logic [8:0] Y_LAST_NTSC = Y_LAST_NTSC_DEFAULT,
  parameter logic [8:0] Y_LAST_PAL  = Y_LAST_PAL_DEFAULT
) (
  input  logic       CLK21M,
  input  logic       RESET,
  input  logic       PAL_MODE,
  input  logic       REG_R9_LN,
`ifdef VDP_DOT_TIMING_INTERLACE_EN
  input  logic       REG_R9_IL,
`endif
  output logic [1:0] DOTSTATE,
  output logic [2:0] EIGHTDOTSTATE,
  output logic [8:0] DOTCOUNTERX,
  output logic [8:0] DOTCOUNTERYP,
  output logic       BWINDOW_Y,
  output logic       HSYNC_PULSE,
  output logic       VSYNC_PULSE,
  output logic       FIELD
);

  dotstate_t  ds;
  logic [8:0] x_reg, x_next;
  logic [8:0] y_reg, y_next;
  logic [8:0] y_last;
  logic       x_wrap, y_wrap, mode_load;
  logic       bw_reg, hs_reg, vs_reg, field_reg;
  logic       pal_reg, ln_reg, sample_reg;
`ifdef VDP_DOT_TIMING_INTERLACE_EN
  logic       il_reg;
`endif

  vdp_dot_phase u_phase (
    .CLK21M        (CLK21M),
    .RESET         (RESET),
    .dot_x         (x_reg),
    .dotstate      (ds),
    .eightdotstate (EIGHTDOTSTATE)
  );

  always_comb begin
    y_last = pal_reg ? Y_LAST_PAL : Y_LAST_NTSC;
`ifdef VDP_DOT_TIMING_INTERLACE_EN
    // odd field of an interlaced frame carries one extra line
    y_last = y_last + {8'd0, il_reg & field_reg};
`endif
    x_wrap    = (ds == DS_11) && (x_reg == X_LAST);
    y_wrap    = x_wrap && (y_reg == y_last);
    mode_load = y_wrap || sample_reg;
    x_next    = x_reg;
    if (ds == DS_11) x_next = x_wrap ? X_FIRST : x_reg + 9'd1;
    y_next    = y_reg;
    if (x_wrap) y_next = y_wrap ? Y_FIRST : y_reg + 9'd1;
  end

  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      x_reg      <= X_FIRST;
      y_reg      <= Y_FIRST;
      bw_reg     <= 1'b0;
      hs_reg     <= 1'b0;
      vs_reg     <= 1'b0;
      field_reg  <= 1'b0;
      pal_reg    <= 1'b0;
      ln_reg     <= 1'b0;
      sample_reg <= 1'b1;
`ifdef VDP_DOT_TIMING_INTERLACE_EN
      il_reg     <= 1'b0;
`endif
    end else begin
      sample_reg <= 1'b0;
      if (mode_load) begin
        pal_reg <= PAL_MODE;
        ln_reg  <= REG_R9_LN;
`ifdef VDP_DOT_TIMING_INTERLACE_EN
        il_reg  <= REG_R9_IL;
`endif
      end
      x_reg  <= x_next;
      y_reg  <= y_next;
      bw_reg <= in_window(y_next, ln_reg);
      hs_reg <= x_wrap;
      vs_reg <= y_wrap;
      if (y_wrap) field_reg <= ~field_reg;
    end
  end

  assign DOTSTATE     = ds;
  assign DOTCOUNTERX  = x_reg;
  assign DOTCOUNTERYP = y_reg;
  assign BWINDOW_Y    = bw_reg;
  assign HSYNC_PULSE  = hs_reg;
  assign VSYNC_PULSE  = vs_reg;
  assign FIELD        = field_reg;

endmodule

// File: tb/tb_vdp_dot_timing.sv
// Bench for vdp_dot_timing with a shortened line so whole frames fit the budget.
module tb_vdp_dot_timing;

  localparam int XL = 1;            // shortened X_LAST
  localparam int LD = XL + 8 + 1;   // dots per line

  logic       CLK21M = 1'b0;
  logic       RESET;
  logic       PAL_MODE, REG_R9_LN;
`ifdef VDP_DOT_TIMING_INTERLACE_EN
  logic       REG_R9_IL;
`endif
  logic [1:0] DOTSTATE;
  logic [2:0] EIGHTDOTSTATE;
  logic [8:0] DOTCOUNTERX, DOTCOUNTERYP;
  logic       BWINDOW_Y, HSYNC_PULSE, VSYNC_PULSE, FIELD;

  vdp_dot_timing #(.X_LAST(9'(XL))) dut (
    .CLK21M        (CLK21M),
    .RESET         (RESET),
    .PAL_MODE      (PAL_MODE),
    .REG_R9_LN     (REG_R9_LN),
`ifdef VDP_DOT_TIMING_INTERLACE_EN
    .REG_R9_IL     (REG_R9_IL),
`endif
    .DOTSTATE      (DOTSTATE),
    .EIGHTDOTSTATE (EIGHTDOTSTATE),
    .DOTCOUNTERX   (DOTCOUNTERX),
    .DOTCOUNTERYP  (DOTCOUNTERYP),
    .BWINDOW_Y     (BWINDOW_Y),
    .HSYNC_PULSE   (HSYNC_PULSE),
    .VSYNC_PULSE   (VSYNC_PULSE),
    .FIELD         (FIELD)
  );

  always #5 CLK21M = ~CLK21M;

  int vectors = 0;
  int errors  = 0;

  // Reference model: everything derives from t = edges since reset release.
  int t, my, mfield, mpal, mln, mil;
  bit mhs, mvs;

  function automatic logic [8:0] x_at(input int n);
    return 9'((-8 + (n / 4) % LD) & 511);
  endfunction

  function automatic logic [1:0] ds_at(input int n);
    case (n % 4)
      0: return 2'b10;
      1: return 2'b00;
      2: return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [2:0] eds_at(input int n);
    logic [8:0] xv;
    int e;
    if (n == 0) return 3'd0;
    e  = n - ((n - 1) % 4);
    xv = x_at(e - 1);
    return xv[2:0];
  endfunction

  task automatic model_reset();
    t = 0; my = -8; mfield = 0; mpal = 0; mln = 0; mil = 0; mhs = 0; mvs = 0;
  endtask

  task automatic latch_modes();
    mpal = PAL_MODE; mln = REG_R9_LN;
`ifdef VDP_DOT_TIMING_INTERLACE_EN
    mil = REG_R9_IL;
`endif
  endtask

  task automatic model_step();
    int ylast;
    t++; mhs = 0; mvs = 0;
    if (t == 1) latch_modes();
    if (t % 4 == 0 && (t / 4) % LD == 0) begin
      mhs = 1;
      ylast = (mpal != 0 ? 304 : 264) + ((mil != 0 && mfield != 0) ? 1 : 0);
      if (my == ylast) begin
        my = -8; mvs = 1; mfield ^= 1;
        latch_modes();
      end else my++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
    end
  endtask

  function automatic logic [26:0] dut_vec();
    return {DOTSTATE, EIGHTDOTSTATE, DOTCOUNTERX, DOTCOUNTERYP,
            BWINDOW_Y, HSYNC_PULSE, VSYNC_PULSE, FIELD};
  endfunction

  task automatic cmp_model();
    logic [8:0] y9;
    logic       bw;
    y9 = 9'(my & 511);
    bw = (my >= 0) && (my <= (mln != 0 ? 211 : 191));
    check("outputs", 32'(dut_vec()),
          32'({ds_at(t), eds_at(t), x_at(t), y9, bw, mhs, mvs, mfield[0]}));
  endtask

  task automatic tick();
    @(posedge CLK21M);
    if (!RESET) model_step();
    @(negedge CLK21M);
  endtask

  // Runs one frame up to and including its VSYNC; optionally switches to PAL+LN mid-frame.
  task automatic run_frame(input int chg_line, output int lines, output int bwl, output logic fld);
    int n;
    lines = 0; bwl = 0; fld = 1'b0;
    for (n = 0; n < 16000; n++) begin
      tick();
      cmp_model();
      if (HSYNC_PULSE) begin
        lines++;
        if (BWINDOW_Y) bwl++;
        if (lines == chg_line) begin PAL_MODE = 1'b1; REG_R9_LN = 1'b1; end
        if (lines == 150) fld = FIELD;
      end
      if (VSYNC_PULSE) break;
    end
    if (n == 16000) check("frame_timeout", 32'd1, 32'd0);
    $display("frame: %0d lines, %0d window lines, mid-frame FIELD=%0b", lines, bwl, fld);
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] ds;
    logic [8:0] x;
    logic [2:0] eds;
  } vec_t;

  vec_t vt[10];

  initial begin
    int   lines, bwl, n;
    logic fld;

    vt[0] = '{1'b1, 2'b10, 9'h1F8, 3'd0};
    vt[1] = '{1'b0, 2'b00, 9'h1F8, 3'd0};
    vt[2] = '{1'b0, 2'b01, 9'h1F8, 3'd0};
    vt[3] = '{1'b0, 2'b11, 9'h1F8, 3'd0};
    vt[4] = '{1'b0, 2'b10, 9'h1F9, 3'd0};
    vt[5] = '{1'b0, 2'b00, 9'h1F9, 3'd1};
    vt[6] = '{1'b0, 2'b01, 9'h1F9, 3'd1};
    vt[7] = '{1'b0, 2'b11, 9'h1F9, 3'd1};
    vt[8] = '{1'b0, 2'b10, 9'h1FA, 3'd1};
    vt[9] = '{1'b0, 2'b00, 9'h1FA, 3'd2};

    RESET = 1'b1; PAL_MODE = 1'b0; REG_R9_LN = 1'b0;
`ifdef VDP_DOT_TIMING_INTERLACE_EN
    REG_R9_IL = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge CLK21M);

    for (int i = 0; i < 10; i++) begin
      if (vt[i].rst) begin
        check("reset_state", 32'(dut_vec()), 32'({2'b10, 3'd0, 9'h1F8, 9'h1F8, 4'b0000}));
        RESET = 1'b0;
      end else begin
        tick();
      end
      check("phase_table", 32'({DOTSTATE, DOTCOUNTERX, EIGHTDOTSTATE}),
            32'({vt[i].ds, vt[i].x, vt[i].eds}));
      $display("vec %0d: ds=%b x=%h eds=%0d", i, DOTSTATE, DOTCOUNTERX, EIGHTDOTSTATE);
    end

    // NTSC 192-line frame with a PAL+LN request arriving mid-frame
    run_frame(100, lines, bwl, fld);
    check("ntsc_lines", 32'(lines), 32'd273);
    check("ntsc_window", 32'(bwl), 32'd192);
    check("field_after_ntsc", 32'(FIELD), 32'd1);
    run_frame(0, lines, bwl, fld);
    check("pal_lines", 32'(lines), 32'd313);
    check("pal_window", 32'(bwl), 32'd212);
    check("field_after_pal", 32'(FIELD), 32'd0);

    // randomized mode changes against the model
    for (n = 0; n < 8000; n++) begin
      tick();
      cmp_model();
      if ($urandom_range(0, 1999) == 0) PAL_MODE = ~PAL_MODE;
      if ($urandom_range(0, 1999) == 0) REG_R9_LN = ~REG_R9_LN;
    end
    $display("random segment: %0d clocks, y=%0d", n, my);

    // asynchronous reset in the middle of a line
    for (n = 0; n < 100 && DOTCOUNTERX != 9'h1FC; n++) begin tick(); cmp_model(); end
    check("find_mid_line", 32'(DOTCOUNTERX), 32'h1FC);
    @(posedge CLK21M);
    #1 RESET = 1'b1;
    #1 check("async_reset", 32'(dut_vec()), 32'({2'b10, 3'd0, 9'h1F8, 9'h1F8, 4'b0000}));
    $display("async reset: outputs=%h", dut_vec());
    model_reset();
    PAL_MODE = 1'b0; REG_R9_LN = 1'b0;
`ifdef VDP_DOT_TIMING_INTERLACE_EN
    REG_R9_IL = 1'b1;
`endif
    @(negedge CLK21M);
    cmp_model();
    RESET = 1'b0;

`ifdef VDP_DOT_TIMING_INTERLACE_EN
    run_frame(0, lines, bwl, fld);
    check("il_even_lines", 32'(lines), 32'd273);
    check("il_even_field", 32'(fld), 32'd0);
    run_frame(0, lines, bwl, fld);
    check("il_odd_lines", 32'(lines), 32'd274);
    check("il_odd_field", 32'(fld), 32'd1);
`else
    run_frame(0, lines, bwl, fld);
    check("post_reset_lines", 32'(lines), 32'd273);
    check("post_reset_field", 32'(FIELD), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
